// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: wide adder built from one shared 4-bit ripple slice.
// Operands are captured into shift registers and consumed one nibble per
// cycle, least-significant first, with the slice carry held between steps.
// Valid/ready handshakes on both the operand side and the result side.

// One-bit full adder cell; four of these form the shared nibble slice.
module full_add (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [3:0]       s4;
    logic [4:0]       rc;
    logic             last;
    logic             accept;

    // Shared 4-bit ripple slice working on the low nibble of the shift registers.
    assign rc[0] = carry;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            full_add u_fa (
                .x  (a_sh[gi]),
                .y  (b_sh[gi]),
                .ci (rc[gi]),
                .s  (s4[gi]),
                .co (rc[gi+1])
            );
        end
    endgenerate

    assign last   = (cnt == CW'(NIB - 1));
    assign accept = in_valid & in_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so it lives inside the clocked
        // branch and the sensitivity list holds only the clock.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs straight from the state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, then one nibble per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
        end else if (state == RUN) begin
            for (int n = 0; n < NIB; n++) begin
                if (cnt == CW'(n)) sum[n*4 +: 4] <= s4;
            end
            carry <= rc[4];
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            cnt   <= cnt + 1'b1;
            if (last) cout <= rc[4];
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl: a WIDTH=16 instance for the main
// scenarios and a WIDTH=4 instance for the single-step case. Expected values
// come from plain wide arithmetic on the operands.
module tb_nibble_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;

    logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0] a4, b4, sum4;

    int checks   = 0;
    int failures = 0;

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + 17'(ci);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, let one edge accept them, then count edges to out_valid.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                          output logic [15:0] s, output logic c, output int lat);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL run_op_in_ready: got %b expected 1", in_ready);
        end
        a = ta; b = tbv; cin = tc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        s = sum;
        c = cout;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL finish_op: in_ready=%b out_valid=%b busy=%b expected 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({in_ready, out_valid, busy, cout} !== 4'b1000 || sum !== 16'h0) begin
            failures++;
            $display("FAIL reset16: rdy=%b ov=%b busy=%b cout=%b sum=%h expected 1 0 0 0 0000",
                     in_ready, out_valid, busy, cout, sum);
        end
        checks++;
        if ({in_ready4, out_valid4, busy4, cout4} !== 4'b1000 || sum4 !== 4'h0) begin
            failures++;
            $display("FAIL reset4: rdy=%b ov=%b busy=%b cout=%b sum=%h expected 1 0 0 0 0",
                     in_ready4, out_valid4, busy4, cout4, sum4);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] s; logic c; int lat;
        run_op(16'h1234, 16'h4321, 1'b0, s, c, lat);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL basic_latency: got %0d expected 4", lat); end
        checks++;
        if (s !== 16'h5555 || c !== 1'b0) begin
            failures++; $display("FAIL basic_result: got %h/%b expected 5555/0", s, c);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL basic_done_flags: busy=%b rdy=%b expected 1 0", busy, in_ready);
        end
        finish_op();
        checks++;
        if (sum !== 16'h5555) begin failures++; $display("FAIL basic_sum_held: got %h expected 5555", sum); end
    endtask

    task automatic test_carry();
        logic [15:0] s; logic c; int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, s, c, lat);
        checks++;
        if (s !== 16'h0000 || c !== 1'b1 || lat !== 4) begin
            failures++; $display("FAIL carry_ripple: got %h/%b lat %0d expected 0000/1 lat 4", s, c, lat);
        end
        finish_op();
        run_op(16'hFFFF, 16'h0000, 1'b1, s, c, lat);
        checks++;
        if (s !== 16'h0000 || c !== 1'b1 || lat !== 4) begin
            failures++; $display("FAIL carry_cin: got %h/%b lat %0d expected 0000/1 lat 4", s, c, lat);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        logic [15:0] s; logic c; int lat;
        run_op(16'h8000, 16'h8000, 1'b0, s, c, lat);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: ov=%b sum=%h cout=%b rdy=%b expected 1 0000 1 0",
                         i, out_valid, sum, cout, in_ready);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL backpressure_release: rdy=%b busy=%b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
        step();
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin step(); lat++; end
        checks++;
        if (sum !== 16'h0003 || cout !== 1'b0 || lat !== 4) begin
            failures++; $display("FAIL ignore_first: got %h/%b lat %0d expected 0003/0 lat 4", sum, cout, lat);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || sum !== 16'h0003) begin
            failures++; $display("FAIL ignore_no_same_cycle_accept: rdy=%b sum=%h expected 1 0003", in_ready, sum);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL ignore_held_accept: busy=%b rdy=%b expected 1 0", busy, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin step(); lat++; end
        checks++;
        if (sum !== 16'hFFFF || cout !== 1'b0 || lat !== 4) begin
            failures++; $display("FAIL ignore_second: got %h/%b lat %0d expected ffff/0 lat 4", sum, cout, lat);
        end
        finish_op();
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s; logic c; int lat;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, cout} !== 4'b1000 || sum !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid_run: rdy=%b ov=%b busy=%b cout=%b sum=%h expected 1 0 0 0 0000",
                     in_ready, out_valid, busy, cout, sum);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_discard: ov=%b busy=%b expected 0 0", out_valid, busy);
        end
        run_op(16'h0010, 16'h0020, 1'b0, s, c, lat);
        checks++;
        if (s !== 16'h0030 || c !== 1'b0 || lat !== 4) begin
            failures++; $display("FAIL reset_recover: got %h/%b lat %0d expected 0030/0 lat 4", s, c, lat);
        end
        finish_op();
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa[3];
        logic [15:0] ob[3];
        logic        oc[3];
        int          acc_cyc[3];
        int          idx, got, cyc;
        logic [16:0] exp;
        bit          acc;
        for (int i = 0; i < 3; i++) begin
            oa[i] = 16'($urandom); ob[i] = 16'($urandom); oc[i] = 1'($urandom); acc_cyc[i] = 0;
        end
        idx = 0; got = 0; cyc = 0;
        a = oa[0]; b = ob[0]; cin = oc[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (got < 3 && cyc < 200) begin
            acc = (in_ready === 1'b1) && (idx < 3);
            if (out_valid === 1'b1) begin
                exp = ref_add(oa[got], ob[got], oc[got]);
                checks++;
                if ({cout, sum} !== exp) begin
                    failures++;
                    $display("FAIL b2b_result[%0d]: got %b/%h expected %b/%h", got, cout, sum, exp[16], exp[15:0]);
                end
                got++;
            end
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            step();
            cyc++;
            if (acc) begin
                if (idx < 3) begin
                    a = oa[idx]; b = ob[idx]; cin = oc[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got !== 3) begin failures++; $display("FAIL b2b_count: got %0d results expected 3", got); end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
                failures++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 6", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] s, ta, tbv; logic c, tc; int lat; logic [16:0] exp;
        for (int i = 0; i < 8; i++) begin
            ta = 16'($urandom); tbv = 16'($urandom); tc = 1'($urandom);
            exp = ref_add(ta, tbv, tc);
            run_op(ta, tbv, tc, s, c, lat);
            checks++;
            if ({c, s} !== exp || lat !== 4) begin
                failures++;
                $display("FAIL random[%0d]: %h+%h+%b got %b/%h lat %0d expected %b/%h lat 4",
                         i, ta, tbv, tc, c, s, lat, exp[16], exp[15:0]);
            end
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                step();
                checks++;
                if (out_valid !== 1'b1 || {cout, sum} !== exp) begin
                    failures++;
                    $display("FAIL random_hold[%0d]: ov=%b got %b/%h expected 1 %b/%h",
                             i, out_valid, cout, sum, exp[16], exp[15:0]);
                end
            end
            finish_op();
        end
    endtask

    task automatic test_width4();
        logic [3:0] ta, tbv; logic tc; int lat; logic [4:0] exp;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                ta = 4'hF; tbv = 4'h1; tc = 1'b0;
            end else begin
                ta = 4'($urandom); tbv = 4'($urandom); tc = 1'($urandom);
            end
            exp = {1'b0, ta} + {1'b0, tbv} + 5'(tc);
            checks++;
            if (in_ready4 !== 1'b1) begin failures++; $display("FAIL w4_in_ready[%0d]: got %b expected 1", i, in_ready4); end
            a4 = ta; b4 = tbv; cin4 = tc; in_valid4 = 1'b1;
            step();
            in_valid4 = 1'b0;
            lat = 0;
            while (out_valid4 !== 1'b1 && lat < 20) begin step(); lat++; end
            checks++;
            if ({cout4, sum4} !== exp || lat !== 1) begin
                failures++;
                $display("FAIL w4_result[%0d]: %h+%h+%b got %b/%h lat %0d expected %b/%h lat 1",
                         i, ta, tbv, tc, cout4, sum4, lat, exp[4], exp[3:0]);
            end
            out_ready4 = 1'b1;
            step();
            out_ready4 = 1'b0;
        end
    endtask

    // Bound on total run time in case the DUT never answers.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scenario sequence and final summary.
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_ignore_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_width4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
